// File: rtl/mem_port_arb_if.sv
// Bundle of fetch, load/store and memory-side signals around the memory port arbiter.
// master = arbiter view, slave = core/memory environment view.
interface mem_port_arb_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // Instruction fetch requester
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [31:0]           if_rdata;

  // Load/store requester
  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_wstrb;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arb.sv
// Unified memory port arbiter: grants IF or LS, issues one access, waits for ack or timeout.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed LS-over-IF priority.
module mem_port_arb #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_arb_if.master bus,
  output logic           busy,
  output logic           bus_err
);

  localparam int unsigned      STRB_W    = DATA_W / 8;
  localparam bit               TimeoutEn = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CntLast   = TimeoutEn ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StLsBusy
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                bus_err_q, bus_err_d;

  logic                pick_ls;
  logic                if_gnt;
  logic                ls_gnt;
  logic                timeout_hit;
  logic [31:0]         fetch_word;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_RR_EN
  // prio_ls_q set means LS wins the next tie, i.e. IF was granted last.
  logic prio_ls_q, prio_ls_d;

  assign pick_ls = bus.ls_req & (~bus.if_req | prio_ls_q);

  always_comb begin
    prio_ls_d = prio_ls_q;
    if (ls_gnt) begin
      prio_ls_d = 1'b0;
    end else if (if_gnt) begin
      prio_ls_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_ls_q <= 1'b1;
    end else begin
      prio_ls_q <= prio_ls_d;
    end
  end
`else
  assign pick_ls = bus.ls_req;
`endif

  assign ls_gnt = (state_q == StIdle) & pick_ls;
  assign if_gnt = (state_q == StIdle) & bus.if_req & ~pick_ls;

  // ---------------------------------------------------------------------------
  // Response shaping and watchdog
  // ---------------------------------------------------------------------------
  // Fetch returns the 32-bit half of the data word selected by address bit 2.
  assign fetch_word  = 32'(bus.mem_rdata >> {mem_addr_q[2], 5'd0});
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    bus_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ls_gnt) begin
          state_d     = StLsBusy;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_we ? bus.ls_wdata : '0;
          mem_wstrb_d = bus.ls_we ? bus.ls_wstrb : '1;
        end else if (if_gnt) begin
          state_d     = StIfBusy;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '1;
        end
      end

      StIfBusy, StLsBusy: begin
        if (bus.mem_ack) begin
          // An ack landing on the expiry cycle still completes normally.
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (state_q == StIfBusy) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = fetch_word;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == StIfBusy) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = '0;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = '0;
          end
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = (state_q != StIdle);
  assign bus_err       = bus_err_q;

endmodule
